fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, sitting directly upstream of the decode stage. It owns the PC and fetches words over a req/ack instruction-memory port that tolerates variable latency. It presents a registered `pc`/`instruction` pair to decode, stalls on the hazard unit's freeze, and redirects on taken branches from EXE, squashing any in-flight fetch.

---
 rtl/arm_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 50 +++++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline front end.
// Provides word/address widths, the default bubble instruction and the
// fetch FSM state encoding used by fetch_stage.
package arm_pkg;

  localparam int unsigned WordWidth = 32;
  localparam int unsigned AddrWidth = 32;

  // MOV r0,r0: architecturally a no-op, used as the IF/ID bubble.
  localparam logic [WordWidth-1:0] NopInstrDefault = 32'hE1A0_0000;

  localparam logic [AddrWidth-1:0] WordBytes = 32'd4;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   load_i            capture {pc_i, instr_i} as a valid instruction
//   flush_i           insert a bubble {pc_i, NopInstr, 0}; wins over load_i
//   pc_i, instr_i     next contents
//   pc_o, instr_o     registered contents
//   valid_o           1 = real instruction, 0 = bubble
// With neither load_i nor flush_i the register holds.
module if_id_reg
  import arm_pkg::*;
#(
  parameter logic [WordWidth-1:0] NopInstr = NopInstrDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 flush_i,
  input  logic [AddrWidth-1:0] pc_i,
  input  logic [WordWidth-1:0] instr_i,
  output logic [AddrWidth-1:0] pc_o,
  output logic [WordWidth-1:0] instr_o,
  output logic                 valid_o
);

  logic [AddrWidth-1:0] pc_q;
  logic [WordWidth-1:0] instr_q;
  logic                 valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      pc_q    <= pc_i;
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Owns the PC, fetches over a req/ack memory port of variable latency,
// stalls on freeze and redirects on taken branches, squashing in-flight fetches.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   freeze_i                 hazard stall: hold PC and IF/ID
//   branch_taken_i           redirect request from EXE (priority over freeze)
//   branch_address_i         redirect target
//   imem_req_o, imem_addr_o  fetch request and its word address
//   imem_ack_i, imem_rdata_i read data valid / fetched word
//   pc_o, instruction_o      IF/ID contents (pc is fetch address + 4)
//   valid_o                  IF/ID holds a real instruction
module fetch_stage
  import arm_pkg::*;
#(
  parameter logic [AddrWidth-1:0] ResetPc  = 32'h0000_0000,
  parameter logic [WordWidth-1:0] NopInstr = NopInstrDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 freeze_i,
  input  logic                 branch_taken_i,
  input  logic [AddrWidth-1:0] branch_address_i,
  output logic                 imem_req_o,
  output logic [AddrWidth-1:0] imem_addr_o,
  input  logic                 imem_ack_i,
  input  logic [WordWidth-1:0] imem_rdata_i,
  output logic [AddrWidth-1:0] pc_o,
  output logic [WordWidth-1:0] instruction_o,
  output logic                 valid_o
);

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] next_pc_q, next_pc_d;   // next address to fetch / saved branch target
  logic [AddrWidth-1:0] req_addr_q, req_addr_d; // address of the outstanding request
  logic [WordWidth-1:0] hold_q, hold_d;         // word acked while frozen

  logic                 ifid_load, ifid_flush;
  logic [AddrWidth-1:0] ifid_pc;
  logic [WordWidth-1:0] ifid_instr;
  logic [AddrWidth-1:0] seq_pc;

  assign seq_pc = next_pc_q + WordBytes;

  always_comb begin
    state_d    = state_q;
    next_pc_d  = next_pc_q;
    req_addr_d = req_addr_q;
    hold_d     = hold_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_pc    = req_addr_q + WordBytes;
    ifid_instr = imem_rdata_i;

    if (branch_taken_i) begin
      ifid_flush = 1'b1;
      ifid_pc    = branch_address_i;
      next_pc_d  = branch_address_i;
      unique case (state_q)
        StFetch: begin
          // Without an ack the request cannot be withdrawn, so it is drained in StDrop.
          if (imem_ack_i) req_addr_d = branch_address_i;
          else            state_d    = StDrop;
        end
        StHold: begin
          hold_d     = '0;
          req_addr_d = branch_address_i;
          state_d    = StFetch;
        end
        StDrop: begin
          if (imem_ack_i) begin
            req_addr_d = branch_address_i;
            state_d    = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ack_i) begin
            if (freeze_i) begin
              hold_d  = imem_rdata_i;
              state_d = StHold;
            end else begin
              ifid_load  = 1'b1;
              next_pc_d  = seq_pc;
              req_addr_d = seq_pc;
            end
          end
        end
        StHold: begin
          if (!freeze_i) begin
            ifid_load  = 1'b1;
            ifid_instr = hold_q;
            next_pc_d  = seq_pc;
            req_addr_d = seq_pc;
            state_d    = StFetch;
          end
        end
        StDrop: begin
          if (imem_ack_i) begin
            req_addr_d = next_pc_q;
            state_d    = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StFetch;
      next_pc_q  <= ResetPc;
      req_addr_q <= ResetPc;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
    end
  end

  // Gated by rst_ni so no request is visible while reset is held.
  assign imem_req_o  = rst_ni && (state_q != StHold);
  assign imem_addr_o = req_addr_q;

  if_id_reg #(
    .NopInstr(NopInstr)
  ) u_if_id_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (ifid_load),
    .flush_i(ifid_flush),
    .pc_i   (ifid_pc),
    .instr_i(ifid_instr),
    .pc_o   (pc_o),
    .instr_o(instruction_o),
    .valid_o(valid_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, br, ack, req, valid;
  logic [31:0] br_addr, addr, rdata, pc, instr;

  always #5 clk = ~clk;

  fetch_stage #(
    .ResetPc (32'h0000_0000),
    .NopInstr(Nop)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .freeze_i        (freeze),
    .branch_taken_i  (br),
    .branch_address_i(br_addr),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_ack_i      (ack),
    .imem_rdata_i    (rdata),
    .pc_o            (pc),
    .instruction_o   (instr),
    .valid_o         (valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: IF/ID contents plus what the fetch unit is doing
  // (waiting on a word, sitting on a held word, or draining a squashed word).
  logic [31:0] m_pc, m_instr, m_next, m_req_addr, m_held_word;
  logic        m_valid, m_held, m_drop;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = Nop; m_valid = 1'b0;
    m_next = 32'h0; m_req_addr = 32'h0;
    m_held = 1'b0; m_drop = 1'b0; m_held_word = 32'h0;
  endtask

  task automatic model_step(input logic f, input logic b, input logic [31:0] t,
                            input logic a, input logic [31:0] d);
    logic got;
    got = a && !m_held;
    if (b) begin
      m_pc = t; m_instr = Nop; m_valid = 1'b0;
      m_next = t;
      if (m_held) begin
        m_held = 1'b0; m_req_addr = t;
      end else if (m_drop) begin
        if (got) begin m_drop = 1'b0; m_req_addr = t; end
      end else begin
        if (got) m_req_addr = t;
        else     m_drop = 1'b1;
      end
    end else if (m_held) begin
      if (!f) begin
        m_pc = m_req_addr + 32'd4; m_instr = m_held_word; m_valid = 1'b1;
        m_held = 1'b0; m_next = m_next + 32'd4; m_req_addr = m_next;
      end
    end else if (m_drop) begin
      if (got) begin m_drop = 1'b0; m_req_addr = m_next; end
    end else if (got) begin
      if (f) begin
        m_held = 1'b1; m_held_word = d;
      end else begin
        m_pc = m_req_addr + 32'd4; m_instr = d; m_valid = 1'b1;
        m_next = m_next + 32'd4; m_req_addr = m_next;
      end
    end
  endtask

  task automatic apply(input logic f, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] d);
    freeze = f; br = b; br_addr = t; ack = a; rdata = d;
    model_step(f, b, t, a, d);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_req"}, {31'b0, req}, {31'b0, !m_held});
    if (!m_held) chk({tag, "_addr"}, addr, m_req_addr);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_valid"}, {31'b0, valid}, {31'b0, m_valid});
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  typedef struct {
    logic        f;
    logic        b;
    logic [31:0] t;
    logic        a;
    logic [31:0] d;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic f, input logic b, input logic [31:0] t, input logic a,
                              input logic [31:0] d, input logic er, input logic [31:0] ea,
                              input logic [31:0] ep, input logic [31:0] ei, input logic ev);
    vec_t v;
    v.f = f; v.b = b; v.t = t; v.a = a; v.d = d;
    v.e_req = er; v.e_addr = ea; v.e_pc = ep; v.e_instr = ei; v.e_valid = ev;
    return v;
  endfunction

  int mem_wait;

  task automatic random_cycle();
    logic        f, b, a;
    logic [31:0] t, d;
    f = ($urandom_range(0, 3) == 0);
    b = ($urandom_range(0, 7) == 0);
    t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
    a = 1'b0;
    d = $urandom;
    if (req) begin
      if (mem_wait < 0) mem_wait = int'($urandom_range(0, 3));
      if (mem_wait == 0) begin
        a = 1'b1; d = mem_word(addr); mem_wait = -1;
      end else begin
        mem_wait--;
      end
    end
    apply(f, b, t, a, d);
  endtask

  initial begin
    // f  b  target         ack data           req addr           pc             instr          valid
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h0,          1, 32'h0,          32'h0,          Nop,           0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h4,          1, 32'h4,          32'h4,          32'h0,         1));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h8,          1, 32'h8,          32'h8,          32'h4,         1));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'hC,          32'hC,          32'h8,         1));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'hC,          32'hC,          32'h8,         1));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'hC,          1, 32'hC,          32'hC,          32'h8,         1));
    tbl.push_back(mk(1, 0, 32'h0,          1, 32'hDEAD_0010,  1, 32'h10,         32'h10,         32'hC,         1));
    tbl.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h10,         32'hC,         1));
    tbl.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h10,         32'hC,         1));
    tbl.push_back(mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h10,         32'hC,         1));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h10,         32'hC,         1));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h14,         1, 32'h14,         32'h14,         32'hDEAD_0010, 1));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h18,         1, 32'h18,         32'h18,         32'h14,        1));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h1C,         1, 32'h1C,         32'h1C,         32'h18,        1));
    tbl.push_back(mk(0, 1, 32'h100,        0, 32'h0,          1, 32'h20,         32'h20,         32'h1C,        1));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h20,         32'h100,        Nop,           0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'hBAD0_0020,  1, 32'h20,         32'h100,        Nop,           0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 32'h100,        1, 32'h100,        32'h100,        Nop,           0));
    tbl.push_back(mk(1, 1, 32'h200,        0, 32'h0,          0, 32'h0,          32'h100,        Nop,           0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h200,        1, 32'h200,        32'h200,        Nop,           0));
    tbl.push_back(mk(0, 1, 32'h300,        1, 32'hBAD0_0204,  1, 32'h204,        32'h204,        32'h200,       1));
    tbl.push_back(mk(0, 1, 32'h400,        0, 32'h0,          1, 32'h300,        32'h300,        Nop,           0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFC,  0, 32'h0,          1, 32'h300,        32'h400,        Nop,           0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'hBAD0_0300,  1, 32'h300,        32'hFFFF_FFFC,  Nop,           0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 32'h1234_5678,  1, 32'hFFFF_FFFC,  32'hFFFF_FFFC,  Nop,           0));
    tbl.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h0,          32'h1234_5678, 1));

    // Reset with an ack asserted: must be ignored.
    rst_n = 1'b0; freeze = 1'b0; br = 1'b0; br_addr = 32'h0; ack = 1'b1; rdata = 32'hFFFF_0000;
    mem_wait = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, Nop);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    rst_n = 1'b1; ack = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      apply(tbl[i].f, tbl[i].b, tbl[i].t, tbl[i].a, tbl[i].d);
    end

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      check_model("rand");
      random_cycle();
      if (i == 700) begin
        // Async reset mid-cycle, with an ack offered while held in reset.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req", {31'b0, req}, 32'h0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_instr", instr, Nop);
        chk("mrst_valid", {31'b0, valid}, 32'h0);
        freeze = 1'b0; br = 1'b0; ack = 1'b1; rdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_hold_instr", instr, Nop);
        rst_n = 1'b1; ack = 1'b0;
        model_reset();
        mem_wait = -1;
        #1;
        chk("post_rst_req", {31'b0, req}, 32'h1);
        chk("post_rst_addr", addr, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
